// File: rtl/key_event_scanner.sv
// key_event_scanner: syncs and debounces KEYBOARD, publishes lowest pressed key and queues press/release events.
// Define KEY_ACTIVE_LOW_EN for an active-low KEYBOARD; all outputs stay 1 = pressed.
module key_event_scanner #(
  parameter int NKEYS           = 13,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NKEYS-1:0] KEYBOARD,
  output logic [NKEYS-1:0] keys_stable,
  output logic             any_key,
  output logic [3:0]       active_key,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [4:0]       ev_data,
  output logic             overflow
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
`ifdef KEY_ACTIVE_LOW_EN
  localparam logic [NKEYS-1:0] IDLE = '1;
`else
  localparam logic [NKEYS-1:0] IDLE = '0;
`endif
  logic [NKEYS-1:0] s1_q, s2_q, synced, stable_q, stable_d, flip, press_set, rel_set;
  logic [NKEYS-1:0] press_pend_q, press_pend_d, rel_pend_q, rel_pend_d, pend, sel_oh, clr_p, clr_r;
  logic [CW-1:0] cnt_q [NKEYS];
  logic [CW-1:0] cnt_d [NKEYS];
  logic any_q, any_d, ovf_q, ovf_d, sel_press, push, pop;
  logic [3:0] act_q, act_d, sel_idx;
  logic [4:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  // Sync flops hold raw levels so their reset value is the raw idle level.
  assign synced = s2_q ^ IDLE;
  always_comb begin
    flip = '0;
    for (int i = 0; i < NKEYS; i++) begin
      flip[i] = (synced[i] != stable_q[i]) && (cnt_q[i] == CMAX);
      cnt_d[i] = (synced[i] == stable_q[i] || flip[i]) ? '0 : cnt_q[i] + 1'b1;
    end
    stable_d = stable_q ^ flip;
    press_set = flip & ~stable_q;
    rel_set = flip & stable_q;
    any_d = |stable_q;
    pend = press_pend_q | rel_pend_q;
    act_d = '0;
    sel_idx = '0;
    sel_press = 1'b0;
    sel_oh = '0;
    for (int i = NKEYS-1; i >= 0; i--) begin
      if (stable_q[i]) act_d = 4'(i);
      if (pend[i]) begin
        sel_idx = 4'(i);
        sel_press = press_pend_q[i];
        sel_oh = NKEYS'(1) << i;
      end
    end
    pop = ev_valid && ev_ready;
    push = (|pend) && (count_q != FULL || pop);
    clr_p = (push && sel_press) ? sel_oh : '0;
    clr_r = (push && !sel_press) ? sel_oh : '0;
    press_pend_d = (press_pend_q & ~clr_p) | press_set;
    rel_pend_d = (rel_pend_q & ~clr_r) | rel_set;
    ovf_d = ovf_q | (|(press_set & press_pend_q & ~clr_p)) | (|(rel_set & rel_pend_q & ~clr_r));
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset_n) begin
      s1_q <= IDLE;
      s2_q <= IDLE;
      stable_q <= '0;
      cnt_q <= '{default: '0};
      press_pend_q <= '0;
      rel_pend_q <= '0;
      any_q <= 1'b0;
      act_q <= '0;
      ovf_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      s1_q <= KEYBOARD;
      s2_q <= s1_q;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
      press_pend_q <= press_pend_d;
      rel_pend_q <= rel_pend_d;
      any_q <= any_d;
      act_q <= act_d;
      ovf_q <= ovf_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {sel_press, sel_idx};
  end
  assign keys_stable = stable_q;
  assign any_key = any_q;
  assign active_key = act_q;
  assign ev_valid = count_q != '0;
  assign ev_data = ev_valid ? mem_q[rd_q] : '0;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_key_event_scanner.sv
// tb_key_event_scanner: directed, table-driven and random checks of key_event_scanner against a window/queue model.
module tb_key_event_scanner;
  localparam int NK = 13;
  localparam int D = 4;
  localparam int DEPTH = 4;
`ifdef KEY_ACTIVE_LOW_EN
  localparam logic [NK-1:0] IDLE = '1;
`else
  localparam logic [NK-1:0] IDLE = '0;
`endif
  typedef struct {
    logic [NK-1:0] kb;
    logic          rdy;
    int            n;
    logic [NK-1:0] ks;
    logic          any;
    logic [3:0]    act;
    logic          vld;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic ev_ready = 1'b1;
  logic [NK-1:0] kb = '0;
  logic [NK-1:0] KEYBOARD, keys_stable;
  logic any_key, ev_valid, overflow;
  logic [3:0] active_key;
  logic [4:0] ev_data;
  int checks = 0;
  int errors = 0;
  logic [NK-1:0] m_hist [D+2];
  logic [NK-1:0] m_stable, m_pp, m_rp;
  logic m_any, m_ovf;
  logic [3:0] m_act;
  logic [4:0] m_fifo [$];
  logic [4:0] got [$];
  assign KEYBOARD = kb ^ IDLE;
  always #5 clk = ~clk;
  key_event_scanner #(.NKEYS(NK), .DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .KEYBOARD(KEYBOARD), .keys_stable(keys_stable),
    .any_key(any_key), .active_key(active_key), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_data(ev_data), .overflow(overflow)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Stable flips once the last D synced samples (input delayed two edges) all disagree with it.
  task automatic model_edge();
    logic [NK-1:0] win, ps, rs;
    int sel;
    if (reset_n) begin
      for (int j = 0; j < D+2; j++) m_hist[j] = '0;
      m_stable = '0; m_pp = '0; m_rp = '0;
      m_any = 1'b0; m_act = '0; m_ovf = 1'b0;
      m_fifo.delete();
    end else begin
      for (int j = D+1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = kb;
      win = '1;
      for (int j = 2; j < D+2; j++) win &= m_hist[j] ^ m_stable;
      ps = win & ~m_stable;
      rs = win & m_stable;
      m_any = |m_stable;
      m_act = '0;
      for (int i = 0; i < NK; i++) if (m_stable[i]) begin m_act = 4'(i); break; end
      if (m_fifo.size() > 0 && ev_ready) void'(m_fifo.pop_front());
      sel = -1;
      for (int i = 0; i < NK; i++) if (m_pp[i] || m_rp[i]) begin sel = i; break; end
      if (sel >= 0 && m_fifo.size() < DEPTH) begin
        if (m_pp[sel]) begin m_fifo.push_back({1'b1, 4'(sel)}); m_pp[sel] = 1'b0; end
        else begin m_fifo.push_back({1'b0, 4'(sel)}); m_rp[sel] = 1'b0; end
      end
      if ((|(ps & m_pp)) || (|(rs & m_rp))) m_ovf = 1'b1;
      m_pp |= ps;
      m_rp |= rs;
      m_stable ^= win;
    end
  endtask
  task automatic step();
    logic x;
    logic [4:0] d;
    x = ev_valid && ev_ready;
    d = ev_data;
    @(posedge clk);
    model_edge();
    #1;
    if (x) got.push_back(d);
    chk("keys_stable", keys_stable, m_stable);
    chk("any_key", any_key, m_any);
    chk("active_key", active_key, m_act);
    chk("ev_valid", ev_valid, m_fifo.size() > 0);
    chk("ev_data", ev_data, m_fifo.size() > 0 ? m_fifo[0] : 5'd0);
    chk("overflow", overflow, m_ovf);
  endtask
  task automatic expect_ev(input string name, input logic [4:0] exp [$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
  endtask
  initial begin
    vec_t tbl [8];
    logic [4:0] q [$];
    tbl[0] = '{13'h0010, 1'b1, 10, 13'h0010, 1'b1, 4'd4, 1'b0};
    tbl[1] = '{13'h0110, 1'b1, 10, 13'h0110, 1'b1, 4'd4, 1'b0};
    tbl[2] = '{13'h0100, 1'b1, 10, 13'h0100, 1'b1, 4'd8, 1'b0};
    tbl[3] = '{13'h1000, 1'b1, 10, 13'h1000, 1'b1, 4'd12, 1'b0};
    tbl[4] = '{13'h1003, 1'b1, 10, 13'h1003, 1'b1, 4'd0, 1'b0};
    tbl[5] = '{13'h0000, 1'b1, 10, 13'h0000, 1'b0, 4'd0, 1'b0};
    tbl[6] = '{13'h0800, 1'b1, 2, 13'h0000, 1'b0, 4'd0, 1'b0};
    tbl[7] = '{13'h0000, 1'b1, 10, 13'h0000, 1'b0, 4'd0, 1'b0};
    kb = 13'h1FFF;
    repeat (3) step();
    chk("rst_ks", keys_stable, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_data", ev_data, 0);
    reset_n = 1'b0;
    got.delete();
    repeat (5) step();
    chk("rst_ks_early", keys_stable, 0);
    step();
    chk("rst_ks_all", keys_stable, 13'h1FFF);
    repeat (20) step();
    q.delete();
    for (int i = 0; i < NK; i++) q.push_back({1'b1, 4'(i)});
    expect_ev("rst_press_order", q);
    kb = '0;
    got.delete();
    repeat (20) step();
    q.delete();
    for (int i = 0; i < NK; i++) q.push_back({1'b0, 4'(i)});
    expect_ev("release_order", q);
    got.delete();
    kb = 13'h0020;
    repeat (5) step();
    chk("cp_ks_early", keys_stable[5], 0);
    step();
    chk("cp_ks", keys_stable[5], 1);
    chk("cp_valid_early", ev_valid, 0);
    chk("cp_any_lag", any_key, 0);
    step();
    chk("cp_valid", ev_valid, 1);
    chk("cp_data", ev_data, 5'b1_0101);
    chk("cp_active", active_key, 5);
    chk("cp_any", any_key, 1);
    kb = '0;
    repeat (12) step();
    expect_ev("cp_events", '{5'b1_0101, 5'b0_0101});
    got.delete();
    kb = 13'h0004;
    repeat (3) step();
    kb = '0;
    repeat (10) step();
    chk("glitch_ks", keys_stable, 0);
    chk("glitch_events", got.size(), 0);
    ev_ready = 1'b0;
    got.delete();
    kb = 13'h003F;
    repeat (12) step();
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", ev_valid, 1);
      chk("bp_data", ev_data, 5'b1_0000);
      step();
    end
    ev_ready = 1'b1;
    repeat (12) step();
    expect_ev("bp_events", '{5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15});
    chk("bp_ovf", overflow, 0);
    ev_ready = 1'b0;
    got.delete();
    kb = '0;
    repeat (12) step();
    kb = 13'h0080;
    repeat (6) step();
    kb = '0;
    repeat (6) step();
    kb = 13'h0080;
    repeat (8) step();
    chk("merge_ovf", overflow, 1);
    chk("merge_ks7", keys_stable[7], 1);
    ev_ready = 1'b1;
    repeat (15) step();
    expect_ev("merge_events", '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h17, 5'h07});
    chk("merge_ovf_sticky", overflow, 1);
    ev_ready = 1'b0;
    kb = '0;
    repeat (8) step();
    chk("midhs_valid", ev_valid, 1);
    reset_n = 1'b1;
    step();
    chk("midhs_valid_rst", ev_valid, 0);
    chk("midhs_ovf_rst", overflow, 0);
    chk("midhs_ks_rst", keys_stable, 0);
    reset_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      kb = tbl[k].kb;
      ev_ready = tbl[k].rdy;
      repeat (tbl[k].n) step();
      chk("tbl_ks", keys_stable, tbl[k].ks);
      chk("tbl_any", any_key, tbl[k].any);
      chk("tbl_act", active_key, tbl[k].act);
      chk("tbl_valid", ev_valid, tbl[k].vld);
    end
    for (int r = 0; r < 200; r++) begin
      if ($urandom_range(0, 1) == 0) kb ^= NK'(1) << $urandom_range(0, NK-1);
      else kb = NK'($urandom);
      reset_n = ($urandom_range(0, 60) == 0);
      for (int c = $urandom_range(1, 12); c > 0; c--) begin
        ev_ready = $urandom_range(0, 3) != 0;
        step();
        reset_n = 1'b0;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_event_scanner.md
Name: key_event_scanner

Overview:
- Front-end stage directly upstream of the key and screen/data paths in piano_plus_plus.
- Synchronises and debounces the 13 raw KEYBOARD inputs and publishes a stable key vector.
- Publishes a monophonic note select: lowest pressed key, for note/tone selection.
- Queues press/release events in a small FIFO behind a valid/ready handshake for the data/screen path.

Parameters:
- NKEYS, 13, number of keyboard inputs (max 16).
- DEBOUNCE_CYCLES, 500000, cycles an input must differ from its stable value before the stable value flips (10 ms at 50 MHz); min 2.
- FIFO_DEPTH, 8, event FIFO entries; power of two, min 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-high (reset asserted when reset_n=1).
- KEYBOARD  in  NKEYS  raw asynchronous key inputs; 1 = pressed unless KEY_ACTIVE_LOW_EN.
- keys_stable  out  NKEYS  debounced key state, 1 = pressed.
- any_key  out  1  OR of keys_stable.
- active_key  out  4  index of lowest set bit of keys_stable; 0 when none pressed.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts head this cycle.
- ev_data  out  5  {press(1)=1 / release=0, key index[3:0]}.
- overflow  out  1  sticky: an event was merged/lost.

Behaviour:
- Reset (reset_n=1 at clk edge): sync flops to released, counters 0, keys_stable 0, any_key 0, active_key 0, pending bits 0, FIFO empty, ev_valid 0, ev_data 0, overflow 0. Reset mid-debounce or mid-handshake discards all state; queued events are lost.
- Synchroniser: 2 flops per key; the synced value is used everywhere below.
- Debounce, per key: if synced == keys_stable[i], counter clears to 0. Else counter increments; on the edge where the counter equals DEBOUNCE_CYCLES-1, keys_stable[i] flips and the counter clears.
- Debounce latency: input held from cycle 0 makes keys_stable change at cycle DEBOUNCE_CYCLES+2.
- Glitches shorter than DEBOUNCE_CYCLES produce no change.
- Edge capture: the keys_stable flip sets press_pend[i] (0→1) or rel_pend[i] (1→0) on the same edge.
- If the same-type pending bit is already set, it stays set and overflow sets.
- Encoder, one push per cycle when the FIFO can accept:
  - Selects the lowest index with any pending bit; press before release at the same index.
  - Clears the selected pending bit.
  - Bits set on the same edge are still seen next cycle.
- FIFO full: pending bits hold, no loss. overflow occurs only through the merge case above.
- FIFO accepts a push when not full, or when full with a pop in the same cycle. Pop and push in the same cycle keep the count.
- Handshake:
  - Transfer when ev_valid && ev_ready.
  - ev_data and ev_valid stay stable while ev_valid && !ev_ready.
  - ev_ready while empty has no effect.
- Event latency: ev_valid rises 1 cycle after the keys_stable flip when the FIFO is empty.
- Pointers wrap modulo FIFO_DEPTH; full/empty are derived from a count register (0..FIFO_DEPTH).
- any_key and active_key are registered from keys_stable: 1-cycle lag.
- overflow clears only on reset.

Optional Feature:
- Macro: KEY_ACTIVE_LOW_EN.
- Defined: KEYBOARD bits are inverted at the synchroniser input (0 = pressed). Sync flops reset to raw 1 (logical released).
- Undefined: KEYBOARD is active-high and sync flops reset to 0.
- All outputs keep 1 = pressed semantics in both builds.

Test Plan:
- Bench setting for all scenarios: DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, ev_ready=1 unless stated.
- Reset: reset_n=1 for 3 cycles with KEYBOARD=13'h1FFF -> all outputs 0. After release, keys_stable=13'h1FFF at cycle 6, then 13 press events in index order 0..12.
- Clean press: KEYBOARD[5] 0→1 held -> keys_stable[5]=1 at cycle 6, ev_valid at cycle 7 with ev_data=5'b1_0101; active_key=5, any_key=1.
- Glitch: KEYBOARD[2] high for 3 cycles then low -> no keys_stable change, no event.
- Backpressure: ev_ready=0, press keys 0..5 simultaneously -> FIFO holds 4 entries, ev_data stays 5'b1_0000. Raise ev_ready -> events 0,1,2,3,4,5 in order, none lost, overflow=0.
- Merge/overflow: ev_ready=0, FIFO full; press, release, press key 7, each held 6 cycles -> overflow=1. Draining yields one press(7) and one release(7) beyond the initial entries.
- Rebuild with KEY_ACTIVE_LOW_EN, KEYBOARD idle 13'h1FFF -> no events. KEYBOARD[0]=0 -> keys_stable[0]=1 at cycle 6, event 5'b1_0000.
